// File: rtl/led_blinker.sv
// led_blinker: multi-channel LED driver with a shared 1 ms prescaler and OFF/ON/BLINK modes.
// Define LED_BREATHE_EN to build the BREATHE mode (otherwise mode 3 behaves as BLINK).
module led_blinker #(
    parameter int CLOCK_MHZ = 50,
    parameter int CHANNELS  = 4,
    parameter int PERIOD_W  = 16,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [PERIOD_W-1:0] cfg_duty,
    output logic                tick_ms,
    output logic [CHANNELS-1:0] led
);
    localparam int TC   = CLOCK_MHZ * 1000 - 1;
    localparam int PS_W = $clog2(CLOCK_MHZ * 1000);

    typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_BREATHE} mode_e;

    logic [PS_W-1:0]     cnt_q, cnt_d;
    logic                tick_q, tick_d;
    logic [CHANNELS-1:0] led_q, led_d;

    assign tick_d  = cnt_q == PS_W'(TC);
    assign cnt_d   = tick_d ? '0 : cnt_q + 1'b1;
    assign tick_ms = tick_q;
    assign led     = led_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            led_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            led_q  <= led_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        mode_e               mode_q, mode_d;
        logic [PERIOD_W-1:0] period_q, period_d, duty_q, duty_d, phase_q, phase_d, thr;
        logic                hit, busy, run, wrap;

        assign hit  = cfg_we && (int'(cfg_ch) == g);
        assign busy = (mode_q == M_BLINK) || (mode_q == M_BREATHE);
        assign run  = tick_q && busy && (period_q != '0);
        assign wrap = run && (phase_q == period_q - 1'b1);

        always_comb begin
            mode_d   = hit ? mode_e'(cfg_mode) : mode_q;
            period_d = hit ? cfg_period : period_q;
            duty_d   = hit ? cfg_duty : duty_q;
            phase_d  = (hit || wrap) ? '0 : run ? phase_q + 1'b1 : phase_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                mode_q   <= M_OFF;
                period_q <= '0;
                duty_q   <= '0;
                phase_q  <= '0;
            end else begin
                mode_q   <= mode_d;
                period_q <= period_d;
                duty_q   <= duty_d;
                phase_q  <= phase_d;
            end
        end

`ifdef LED_BREATHE_EN
        logic [PERIOD_W-1:0] bduty_q, bduty_d, bstep;
        logic                bdir_q, bdir_d;
        logic                bmove;

        // bdir_q: 0 = ramping up toward period, 1 = ramping down toward 0
        assign bstep = bdir_q ? bduty_q - 1'b1 : bduty_q + 1'b1;
        assign bmove = wrap && (mode_q == M_BREATHE) && (period_q > PERIOD_W'(1));
        assign thr   = (mode_q == M_BREATHE) ? bduty_q : duty_q;

        always_comb begin
            bduty_d = hit ? '0 : bmove ? bstep : bduty_q;
            bdir_d  = hit ? 1'b0 : bmove ? (bdir_q ? (bstep != '0) : (bstep == period_q)) : bdir_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                bduty_q <= '0;
                bdir_q  <= 1'b0;
            end else begin
                bduty_q <= bduty_d;
                bdir_q  <= bdir_d;
            end
        end
`else
        assign thr = duty_q;
`endif

        assign led_d[g] = (mode_q == M_ON) || (busy && (period_q != '0) && (phase_q < thr));
    end
endmodule

// File: tb/tb_led_blinker.sv
// tb_led_blinker: randomized + directed bench for led_blinker against a tick-counting reference model.
// The model derives phase and breathe level arithmetically from the number of ms ticks since each write.
module tb_led_blinker;
    localparam int CLOCK_MHZ = 1;
    localparam int CHANNELS  = 3;
    localparam int PERIOD_W  = 8;
    localparam int CH_W      = 2;
    localparam int MS        = CLOCK_MHZ * 1000;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_we = 1'b0;
    logic [CH_W-1:0]     cfg_ch = '0;
    logic [1:0]          cfg_mode = '0;
    logic [PERIOD_W-1:0] cfg_period = '0;
    logic [PERIOD_W-1:0] cfg_duty = '0;
    logic                tick_ms;
    logic [CHANNELS-1:0] led;

    led_blinker #(.CLOCK_MHZ(CLOCK_MHZ), .CHANNELS(CHANNELS), .PERIOD_W(PERIOD_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_period(cfg_period), .cfg_duty(cfg_duty), .tick_ms(tick_ms), .led(led)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    int m_cyc = 0;
    int m_n[CHANNELS];
    int m_mode[CHANNELS];
    int m_per[CHANNELS];
    int m_duty[CHANNELS];
    logic [CHANNELS-1:0] exp_led = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, m_cyc, got, exp);
        end
    endtask

    function automatic logic model_led(input int c);
        int p, ph, w, lvl;
        p = m_per[c];
        if (m_mode[c] == 0) return 1'b0;
        if (m_mode[c] == 1) return 1'b1;
        if (p == 0) return 1'b0;
        ph = m_n[c] % p;
`ifdef LED_BREATHE_EN
        if (m_mode[c] == 3) begin
            w = (m_n[c] / p) % (2 * p);
            lvl = (p < 2) ? 0 : (w <= p) ? w : 2 * p - w;
            return ph < lvl;
        end
`endif
        w = 0;
        lvl = m_duty[c];
        return ph < lvl;
    endfunction

    // Tick is present during the cycle after every MS-th edge since reset release.
    function automatic logic model_tick();
        return (m_cyc != 0) && (m_cyc % MS == 0);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cyc <= 0;
            exp_led <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                m_n[c] <= 0; m_mode[c] <= 0; m_per[c] <= 0; m_duty[c] <= 0;
            end
        end else begin
            m_cyc <= m_cyc + 1;
            for (int c = 0; c < CHANNELS; c++) begin
                exp_led[c] <= model_led(c);
                if (cfg_we && int'(cfg_ch) == c) begin
                    m_mode[c] <= int'(cfg_mode);
                    m_per[c]  <= int'(cfg_period);
                    m_duty[c] <= int'(cfg_duty);
                    m_n[c]    <= 0;
                end else if (model_tick() && m_mode[c] >= 2 && m_per[c] != 0) begin
                    m_n[c] <= m_n[c] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("led", 32'(led), 32'(exp_led));
            check("tick_ms", 32'(tick_ms), 32'(model_tick()));
        end
    end

    task automatic wr(input int ch, input int mode, input int per, input int duty);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_ch = CH_W'(ch);
        cfg_mode = 2'(mode);
        cfg_period = PERIOD_W'(per);
        cfg_duty = PERIOD_W'(duty);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic run_ms(input int n);
        repeat (n * MS) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        wr(0, 2, 4, 1);
        wr(1, 2, 2, 1);
        run_ms(8);
        wr(2, 1, 0, 0);
        wr(0, 2, 0, 3);
        wr(1, 2, 5, 0);
        wr(2, 2, 5, 7);
        run_ms(6);
        wr(3, 1, 9, 9);
        run_ms(2);
        wr(0, 2, 4, 2);
        wr(1, 2, 3, 1);
        for (int i = 0; i < MS && (m_cyc % MS) != MS - 1; i++) @(negedge clk);
        wr(0, 2, 4, 1);
        run_ms(5);
        wr(1, 3, 3, 1);
        run_ms(22);
        repeat (700) @(negedge clk);
        rst = 1'b1;
        cfg_we = 1'b1;
        cfg_ch = 2'd2;
        cfg_mode = 2'd1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cfg_we = 1'b0;
        run_ms(2);
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(1000, 20)) @(negedge clk);
            wr($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(6, 0), $urandom_range(7, 0));
        end
        run_ms(3);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
